fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port StallF  input  1  from hazard unit; blocks new fetch requests and PC advance.
REQ-004 SHALL have port StallD  input  1  from hazard unit; holds the decode register.
REQ-005 SHALL have port FlushD  input  1  from hazard unit; loads a bubble into the decode register.
REQ-006 SHALL have port PCSrcE  input  1  taken branch/jump from the execute stage.
REQ-007 SHALL have port PCTargetE  input  32  redirect target address.
REQ-008 SHALL have ports IReqValid output 1, IReqAddr output 32, IReqReady input 1  instruction memory request handshake.
REQ-009 SHALL have ports IRespValid input 1, IRespData input 32  in-order instruction memory response; no backpressure.
REQ-010 SHALL have ports InstrD output 32, PCD output 32, PCPlus4D output 32, ValidD output 1  decode register contents.

Function
REQ-011 SHALL keep a fetch PC (PCF); a request transfers when IReqValid & IReqReady, after which PCF <= PCF+4.
REQ-012 SHALL drive IReqValid/IReqAddr from registers; once IReqValid is high, IReqAddr SHALL stay stable until the transfer, including across a redirect.
REQ-013 SHALL hold a 2-entry instruction queue of {instr, pc} and issue only when outstanding + queue occupancy < 2 and StallF=0.
REQ-014 SHALL write every non-discarded response into the queue tail in the response cycle; queue overflow is unreachable by REQ-013.
REQ-015 SHALL, when StallD=0 and FlushD=0, pop the queue head into the decode register with ValidD=1, or load a bubble if the queue is empty.
REQ-016 Bubble SHALL be InstrD=32'h00000013, PCD=0, PCPlus4D=4, ValidD=0.
REQ-017 Minimum latency SHALL be: transfer in cycle N, response in N+1, decode register valid in N+2 (same-cycle bypass from IRespData allowed when queue empty).
REQ-018 On PCSrcE=1 the unit SHALL: set PCF <= PCTargetE, empty the queue, load a bubble into decode, and mark all outstanding plus same-cycle-accepted requests for discard.
REQ-019 SHALL track discards with a 2-bit counter decremented on each IRespValid; responses arriving while counter>0 SHALL NOT enter the queue.
REQ-020 Priority SHALL be reset > PCSrcE > FlushD > StallD; StallD with an empty queue holds the existing decode contents.
REQ-021 StallF=1 SHALL not drop an already-asserted IReqValid (REQ-012) and SHALL not block response capture.
REQ-022 PCF and PCPlus4D arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.

Reset
REQ-023 On reset: PCF=0, IReqValid=0, IReqAddr=0, queue empty, discard counter=0, decode register = bubble.
REQ-024 Reset asserted mid-transaction SHALL drop outstanding state; responses in the cycle reset is asserted are ignored, and the memory is reset by the same signal.
REQ-025 First request SHALL appear (IReqValid=1, IReqAddr=0) in the first cycle after reset deasserts.

Configuration
REQ-026 With FETCH_MISALIGN_CHECK_EN defined, SHALL add output MisalignF (1 bit, registered) set the cycle after a redirect with PCTargetE[1:0]!=0, with the redirect ignored; cleared by reset only.
REQ-027 Without FETCH_MISALIGN_CHECK_EN, MisalignF SHALL not exist and PCTargetE[1:0] SHALL be forced to 0 on redirect.

Verification
REQ-028 Reset, IReqReady=1, 1-cycle memory returning addr as data -> decode shows PCD 0,4,8 with ValidD=1 on consecutive cycles from cycle 3.
REQ-029 IReqReady=0 for 3 cycles with IReqAddr=8 -> IReqAddr holds 8, transfer on cycle 4, PCF becomes 12.
REQ-030 Two outstanding, PCSrcE=1 PCTargetE=0x100 -> both stale responses discarded, next ValidD=1 shows PCD=0x100, InstrD from 0x100.
REQ-031 StallD=1 four cycles, queue full -> IReqValid stays 0, decode held; release -> PCD increments by 4 with no lost instruction.
REQ-032 FlushD=1 and PCSrcE=1 same cycle -> bubble in decode, PCF=target; FlushD alone with StallD=1 -> bubble wins.
REQ-033 FETCH_MISALIGN_CHECK_EN defined, PCTargetE=0x102 -> MisalignF=1 next cycle, fetch continues sequentially; undefined -> fetch resumes at 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request generation, in-order response capture
// into a 2-entry {instr, pc} queue, and the decode pipeline register.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds the MisalignF flag
// and ignores redirects to non-word-aligned targets; without it the low
// two target bits are cleared.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        IReqValid,
    output logic [31:0] IReqAddr,
    input  logic        IReqReady,
    input  logic        IRespValid,
    input  logic [31:0] IRespData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        MisalignF
`endif
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0] pcF;
    logic [31:0] respPc;        // pc of the next non-discarded response
    logic [1:0]  inFlight;      // accepted requests awaiting a response
    logic [1:0]  discardCnt;    // in-flight responses belonging to a dead path
    logic        staleReq;      // pending request was overtaken by a redirect
    logic [1:0]  qCount;
    logic [31:0] qInstr [2];
    logic [31:0] qPc    [2];

    logic        fire, redirect, respAccept, decodeAdvance;
    logic        popQ, bypass, pushQ, issue, staleNext, wIdx;
    logic [31:0] target, pcFNext;
    logic [1:0]  inFlightNext, qCountNext, discardNext;
    logic [31:0] qInstrNext [2];
    logic [31:0] qPcNext    [2];

    // Next-state computation for fetch PC, request issue, queue and discard tracking
    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect = PCSrcE && (PCTargetE[1:0] == 2'b00);
        target   = PCTargetE;
`else
        redirect = PCSrcE;
        target   = PCTargetE & 32'hFFFF_FFFC;
`endif
        fire          = IReqValid && IReqReady;
        respAccept    = IRespValid && (discardCnt == 2'd0) && !redirect;
        decodeAdvance = !redirect && !FlushD && !StallD;
        popQ          = decodeAdvance && (qCount != 2'd0);
        bypass        = decodeAdvance && (qCount == 2'd0) && respAccept;
        pushQ         = respAccept && !bypass;

        inFlightNext = inFlight + {1'b0, fire} - {1'b0, IRespValid};
        qCountNext   = redirect ? 2'd0 : (qCount + {1'b0, pushQ} - {1'b0, popQ});

        if (redirect)
            pcFNext = target;
        else if (fire && !staleReq)
            pcFNext = pcF + 32'd4;
        else
            pcFNext = pcF;

        issue = (!IReqValid || fire) && !StallF
                && (({1'b0, inFlightNext} + {1'b0, qCountNext}) < 3'd2);

        if (redirect) begin
            discardNext = inFlightNext;
            staleNext   = IReqValid && !fire;
        end else begin
            discardNext = discardCnt;
            if (IRespValid && (discardCnt != 2'd0))
                discardNext = discardNext - 2'd1;
            if (fire && staleReq)
                discardNext = discardNext + 2'd1;
            staleNext = staleReq && !fire;
        end

        wIdx = (qCount == 2'd2) || ((qCount == 2'd1) && !popQ);
        qInstrNext[0] = qInstr[0];
        qInstrNext[1] = qInstr[1];
        qPcNext[0]    = qPc[0];
        qPcNext[1]    = qPc[1];
        if (popQ) begin
            qInstrNext[0] = qInstr[1];
            qPcNext[0]    = qPc[1];
        end
        if (pushQ) begin
            qInstrNext[wIdx] = IRespData;
            qPcNext[wIdx]    = respPc;
        end
    end

    // Fetch-side state: PC, request registers, in-flight and discard bookkeeping, queue
    always_ff @(posedge clk) begin
        if (reset) begin
            pcF        <= '0;
            IReqValid  <= 1'b0;
            IReqAddr   <= '0;
            inFlight   <= '0;
            discardCnt <= '0;
            staleReq   <= 1'b0;
            qCount     <= '0;
            respPc     <= '0;
        end else begin
            pcF <= pcFNext;
            if (issue) begin
                IReqValid <= 1'b1;
                IReqAddr  <= pcFNext;
            end else if (fire) begin
                IReqValid <= 1'b0;
            end
            inFlight   <= inFlightNext;
            discardCnt <= discardNext;
            staleReq   <= staleNext;
            qCount     <= qCountNext;
            if (redirect)
                respPc <= target;
            else if (respAccept)
                respPc <= respPc + 32'd4;
        end
        qInstr[0] <= qInstrNext[0];
        qInstr[1] <= qInstrNext[1];
        qPc[0]    <= qPcNext[0];
        qPc[1]    <= qPcNext[1];
    end

    // Decode register: reset > redirect > flush > stall > queue head / bypass / bubble
    always_ff @(posedge clk) begin
        if (reset || redirect || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= 32'd4;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (qCount != 2'd0) begin
                InstrD   <= qInstr[0];
                PCD      <= qPc[0];
                PCPlus4D <= qPc[0] + 32'd4;
                ValidD   <= 1'b1;
            end else if (respAccept) begin
                InstrD   <= IRespData;
                PCD      <= respPc;
                PCPlus4D <= respPc + 32'd4;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                PCD      <= '0;
                PCPlus4D <= 32'd4;
                ValidD   <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky misaligned-redirect flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            MisalignF <= 1'b0;
        else if (PCSrcE && (PCTargetE[1:0] != 2'b00))
            MisalignF <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit. The instruction memory model returns
// the request address as the instruction word, with latency 1 or 2.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE, IReqReady;
    logic [31:0] PCTargetE;
    logic        IReqValid, IRespValid, ValidD;
    logic [31:0] IReqAddr, IRespData, InstrD, PCD, PCPlus4D;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        MisalignF;
`endif

    int          lat = 1;
    logic        s1v, s2v;
    logic [31:0] s1d, s2d;
    int          nChecks = 0;
    int          nFails  = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .IReqValid(IReqValid), .IReqAddr(IReqAddr), .IReqReady(IReqReady),
        .IRespValid(IRespValid), .IRespData(IRespData),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .MisalignF(MisalignF)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: in-order pipeline, reset by the same signal as the DUT
    always @(posedge clk) begin
        if (reset) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
            s1d <= '0;
            s2d <= '0;
        end else begin
            s1v <= IReqValid && IReqReady;
            s1d <= IReqAddr;
            s2v <= s1v;
            s2d <= s1d;
        end
    end
    assign IRespValid = (lat == 2) ? s2v : s1v;
    assign IRespData  = (lat == 2) ? s2d : s1d;

    typedef struct {
        logic        rst, stF, stD, flD, br;
        logic [31:0] tgt;
        logic        rdy;
        int          lt;
        logic        eIrv;
        logic [31:0] eAddr;
        logic        eV;
        logic [31:0] ePc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, stF, stD, flD, br, input logic [31:0] tgt,
                       input logic rdy, input int lt, input logic eIrv,
                       input logic [31:0] eAddr, input logic eV, input logic [31:0] ePc);
        vec_t v;
        v.rst = rst; v.stF = stF; v.stD = stD; v.flD = flD; v.br = br;
        v.tgt = tgt; v.rdy = rdy; v.lt = lt;
        v.eIrv = eIrv; v.eAddr = eAddr; v.eV = eV; v.ePc = ePc;
        vecs.push_back(v);
    endtask

    // plain running row: no stalls, ready high
    task automatic pl(input int lt, input logic eIrv, input logic [31:0] eAddr,
                      input logic eV, input logic [31:0] ePc);
        add(0, 0, 0, 0, 0, 0, 1, lt, eIrv, eAddr, eV, ePc);
    endtask

    // reset row: everything back to the reset state
    task automatic rs(input int lt);
        add(1, 0, 0, 0, 0, 0, 1, lt, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic step(input logic stF, rdy, br, input logic [31:0] tgt);
        reset = 0; StallF = stF; StallD = 0; FlushD = 0;
        PCSrcE = br; PCTargetE = tgt; IReqReady = rdy;
        @(posedge clk); #1;
    endtask

    task automatic chkDecode(input string tag, input int idx, input logic eV,
                             input logic [31:0] ePc);
        chk({tag, ".ValidD"}, idx, {31'b0, ValidD}, {31'b0, eV});
        chk({tag, ".PCD"}, idx, PCD, ePc);
        chk({tag, ".InstrD"}, idx, InstrD, eV ? ePc : 32'h0000_0013);
        chk({tag, ".PCPlus4D"}, idx, PCPlus4D, ePc + 32'd4);
    endtask

    initial begin
        reset = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
        PCTargetE = 0; IReqReady = 1;

        // sequential fetch, 1-cycle memory
        rs(1); rs(1);
        pl(1, 1, 32'h0, 0, 0);
        pl(1, 1, 32'h4, 0, 0);
        pl(1, 1, 32'h8, 1, 32'h0);
        pl(1, 1, 32'hC, 1, 32'h4);
        pl(1, 1, 32'h10, 1, 32'h8);
        // reset mid-transaction, then request held while not ready
        rs(1); rs(1);
        pl(1, 1, 32'h0, 0, 0);
        pl(1, 1, 32'h4, 0, 0);
        pl(1, 1, 32'h8, 1, 32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8, 1, 32'h4);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8, 0, 0);
        pl(1, 1, 32'hC, 0, 0);
        pl(1, 1, 32'h10, 1, 32'h8);
        pl(1, 1, 32'h14, 1, 32'hC);
        // 2-cycle memory, redirect with two requests outstanding
        rs(2); rs(2);
        pl(2, 1, 32'h0, 0, 0);
        pl(2, 1, 32'h4, 0, 0);
        pl(2, 0, 32'h4, 0, 0);
        add(0, 0, 0, 0, 1, 32'h100, 1, 2, 1, 32'h100, 0, 0);
        pl(2, 1, 32'h104, 0, 0);
        pl(2, 0, 32'h104, 0, 0);
        pl(2, 1, 32'h108, 1, 32'h100);
        pl(2, 1, 32'h10C, 1, 32'h104);
        pl(2, 0, 32'h10C, 0, 0);
        // decode stall fills the queue, release drains it in order
        rs(1); rs(1);
        pl(1, 1, 32'h0, 0, 0);
        pl(1, 1, 32'h4, 0, 0);
        pl(1, 1, 32'h8, 1, 32'h0);
        add(0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h8, 1, 32'h0);
        add(0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h8, 1, 32'h0);
        add(0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h8, 1, 32'h0);
        add(0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h8, 1, 32'h0);
        pl(1, 1, 32'hC, 1, 32'h4);
        pl(1, 1, 32'h10, 1, 32'h8);
        pl(1, 1, 32'h14, 1, 32'hC);
        // flush together with redirect; then flush under decode stall
        add(0, 0, 0, 1, 1, 32'h200, 1, 1, 1, 32'h200, 0, 0);
        pl(1, 1, 32'h204, 0, 0);
        pl(1, 1, 32'h208, 1, 32'h200);
        add(0, 0, 1, 1, 0, 0, 1, 1, 0, 32'h208, 0, 0);
        pl(1, 1, 32'h20C, 1, 32'h204);
        pl(1, 1, 32'h210, 1, 32'h208);
        pl(1, 1, 32'h214, 1, 32'h20C);
        // redirect to a misaligned target
`ifdef FETCH_MISALIGN_CHECK_EN
        add(0, 0, 0, 0, 1, 32'h102, 1, 1, 1, 32'h218, 1, 32'h210);
        pl(1, 1, 32'h21C, 1, 32'h214);
        pl(1, 1, 32'h220, 1, 32'h218);
`else
        add(0, 0, 0, 0, 1, 32'h102, 1, 1, 1, 32'h100, 0, 0);
        pl(1, 1, 32'h104, 0, 0);
        pl(1, 1, 32'h108, 1, 32'h100);
`endif
        // address wrap at the top of the address space
        rs(1); rs(1);
        pl(1, 1, 32'h0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 1, 1, 1, 32'hFFFF_FFF8, 0, 0);
        pl(1, 1, 32'hFFFF_FFFC, 0, 0);
        pl(1, 1, 32'h0, 1, 32'hFFFF_FFF8);
        pl(1, 1, 32'h4, 1, 32'hFFFF_FFFC);
        pl(1, 1, 32'h8, 1, 32'h0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; StallF = vecs[i].stF; StallD = vecs[i].stD;
            FlushD = vecs[i].flD; PCSrcE = vecs[i].br; PCTargetE = vecs[i].tgt;
            IReqReady = vecs[i].rdy; lat = vecs[i].lt;
            @(posedge clk); #1;
            chk("IReqValid", i, {31'b0, IReqValid}, {31'b0, vecs[i].eIrv});
            chk("IReqAddr", i, IReqAddr, vecs[i].eAddr);
            chkDecode("tbl", i, vecs[i].eV, vecs[i].ePc);
        end

        // StallF keeps a raised request and does not block response capture
        reset = 1; lat = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("MisalignF.reset", 0, {31'b0, MisalignF}, 32'd0);
`endif
        step(0, 1, 0, 0);
        chk("H.IReqValid", 1, {31'b0, IReqValid}, 32'd1);
        step(1, 0, 0, 0);
        chk("H.IReqValid", 2, {31'b0, IReqValid}, 32'd1);
        step(1, 0, 0, 0);
        chk("H.IReqValid", 3, {31'b0, IReqValid}, 32'd1);
        chk("H.IReqAddr", 3, IReqAddr, 32'h0);
        step(1, 1, 0, 0);
        chk("H.IReqValid", 4, {31'b0, IReqValid}, 32'd0);
        step(1, 1, 0, 0);
        chk("H.IReqValid", 5, {31'b0, IReqValid}, 32'd0);
        chkDecode("H", 5, 1'b1, 32'h0);
        step(0, 1, 0, 0);
        chk("H.IReqValid", 6, {31'b0, IReqValid}, 32'd1);
        chk("H.IReqAddr", 6, IReqAddr, 32'h4);
        chkDecode("H", 6, 1'b0, 32'h0);
        step(0, 1, 1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("H.MisalignF", 7, {31'b0, MisalignF}, 32'd1);
        chk("H.IReqAddr", 7, IReqAddr, 32'h8);
`else
        chk("H.IReqAddr", 7, IReqAddr, 32'h100);
        chkDecode("H", 7, 1'b0, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
